hls_deadlock_monitor_param: RTL
===============================

HLS_DEADLOCK_MONITOR_PARAM -- requirements
Module: hls_deadlock_monitor_param

Interface
REQ-001 Parameter N_CHAN, default 6: number of AXIS channels monitored (2..32); channel 0 is the current-instance axis.
REQ-002 Parameter PAR_MASK, default 6'b000110: bit i = 1 puts channel i in the parallel sub-group; bit 0 is ignored (channel 0 is never parallel).
REQ-003 Parameter CNT_W, default 16: width of the threshold, persistence counter and block-duration counter.
REQ-004 Parameter STICKY, default 0: 1 latches the block indication until an explicit clear.
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (reset == 0 resets on the next rising edge).
REQ-007 axis_block_sigs  input  N_CHAN  per-channel AXIS blocked indication.
REQ-008 inst_idle_sigs  input  N_CHAN  per-channel sub-instance idle indication.
REQ-009 threshold  input  CNT_W  consecutive raw-block cycles required before flagging; value 0 is treated as 1.
REQ-010 clear  input  1  synchronous clear of detection state.
REQ-011 block  output  1  registered deadlock flag.
REQ-012 axis_block_info  output  N_CHAN  snapshot of blocked channels; forced to 0 whenever block == 0.
REQ-013 first_idx  output  5  lowest blocked channel index in the snapshot; 0 when block == 0.
REQ-014 block_cycles  output  CNT_W  cycles spent in BLOCKED, saturating at all-ones.

Function
REQ-015 raw_block: combinational OR of (a) axis_block_sigs[0], (b) axis_block_sigs[i] for each non-parallel i >= 1, (c) for each parallel i: axis_block_sigs[i] AND, for every other parallel j, (axis_block_sigs[j] OR inst_idle_sigs[j]).
REQ-016 Empty parallel group (PAR_MASK[N_CHAN-1:1] == 0): term (c) is constant 0; a single-member group reduces to axis_block_sigs[i].
REQ-017 FSM states: IDLE, SUSPECT, BLOCKED; block = (state == BLOCKED).
REQ-018 IDLE: raw_block = 1 -> cnt <= 1; next BLOCKED if effective threshold == 1, else SUSPECT. raw_block = 0 -> stay, cnt <= 0.
REQ-019 SUSPECT: raw_block = 0 -> IDLE, cnt <= 0; raw_block = 1 -> cnt <= cnt + 1; next BLOCKED when cnt + 1 >= effective threshold.
REQ-020 Threshold is sampled live each cycle; lowering it mid-SUSPECT to <= cnt + 1 enters BLOCKED on that edge.
REQ-021 Latency: raw_block continuously high from cycle t -> block first high in cycle t + T (T = effective threshold).
REQ-022 Any raw_block drop in SUSPECT restarts counting; no glitch of block.
REQ-023 BLOCKED, STICKY = 0: raw_block = 0 -> IDLE; block low the following cycle.
REQ-024 BLOCKED, STICKY = 1: hold regardless of raw_block until clear or reset.
REQ-025 On the IDLE/SUSPECT -> BLOCKED transition, info register <= axis_block_sigs and first_idx <= lowest set bit of axis_block_sigs (0 if none); neither updates while in BLOCKED.
REQ-026 block_cycles <= 1 on BLOCKED entry, +1 per cycle in BLOCKED, saturating at 2^CNT_W-1; reads 0 outside BLOCKED.
REQ-027 clear = 1: next state IDLE; cnt, info, first_idx, block_cycles <= 0. The clear cycle does not count toward the threshold, even with raw_block = 1.
REQ-028 cnt saturates at 2^CNT_W-1 and never wraps.

Reset
REQ-029 reset == 0 has priority over clear: state IDLE, cnt 0; block, axis_block_info, first_idx, block_cycles all 0 from the next edge.
REQ-030 Reset asserted mid-SUSPECT or mid-BLOCKED aborts immediately; no snapshot survives reset.

Verification
REQ-031 Defaults, threshold = 1; axis_block_sigs = 6'b000001 held -> block = 1 one cycle later; axis_block_info = 000001; first_idx = 0.
REQ-032 threshold = 4; axis_block_sigs[3] high for 3 cycles, low 1 cycle, high 4 cycles -> block stays 0 through the first burst, rises on the 4th cycle after the second burst starts; first_idx = 3.
REQ-033 Parallel group {1,2}: sigs[1] = 1, sigs[2] = 0, idle[2] = 0 -> block stays 0; then idle[2] = 1 -> block rises after T cycles; info = 000010.
REQ-034 STICKY = 1, threshold = 2: block for 2 cycles, drop raw_block -> block holds and block_cycles keeps counting; pulse clear -> block = 0 and all outputs 0 next cycle.
REQ-035 CNT_W = 3, STICKY = 0: block held 10 cycles -> block_cycles saturates at 7. Then assert reset (0) together with clear during BLOCKED -> all outputs 0 next edge.

Source files
------------

// File: rtl/hls_deadlock_monitor_param_if.sv
// Monitor bundle: per-channel blocked/idle inputs, threshold/clear controls and the registered deadlock report.
interface hls_deadlock_monitor_param_if #(
    parameter int N_CHAN = 6,
    parameter int CNT_W  = 16
);
    logic [N_CHAN-1:0] axis_block_sigs;
    logic [N_CHAN-1:0] inst_idle_sigs;
    logic [CNT_W-1:0]  threshold;
    logic              clear;
    logic              block;
    logic [N_CHAN-1:0] axis_block_info;
    logic [4:0]        first_idx;
    logic [CNT_W-1:0]  block_cycles;

    modport master (
        output axis_block_sigs, inst_idle_sigs, threshold, clear,
        input  block, axis_block_info, first_idx, block_cycles
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, threshold, clear,
        output block, axis_block_info, first_idx, block_cycles
    );
endinterface

// File: rtl/hls_deadlock_monitor_param.sv
// HLS deadlock monitor: flags blocked AXIS channels after threshold consecutive raw-block cycles.
// Latency: block rises T edges after raw_block goes high; passive observer, applies no backpressure.
module hls_deadlock_monitor_param #(
    parameter int                N_CHAN   = 6,
    parameter logic [N_CHAN-1:0] PAR_MASK = N_CHAN'(6'b000110),
    parameter int                CNT_W    = 16,
    parameter bit                STICKY   = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    hls_deadlock_monitor_param_if.slave mon
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SUSPECT = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    // Channel 0 is the current instance axis and never joins the parallel group.
    localparam logic [N_CHAN-1:0] PAR_EFF = PAR_MASK & ~{{(N_CHAN-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [N_CHAN-1:0] info_q;
    logic [4:0]        fidx_q;
    logic [CNT_W-1:0]  bc_q;

    logic [N_CHAN-1:0] chan_term;
    logic              raw_block;
    logic [4:0]        fidx_nxt;
    logic [CNT_W-1:0]  thr_eff;
    logic [CNT_W:0]    cnt_p1;
    logic [CNT_W:0]    bc_p1;
    logic [CNT_W-1:0]  cnt_sat;
    logic [CNT_W-1:0]  bc_sat;
    logic              reach;

    // A parallel channel only counts as blocked when every sibling is also blocked or idle.
    always_comb begin
        chan_term = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            chan_term[i] = mon.axis_block_sigs[i];
            if (PAR_EFF[i]) begin
                for (int j = 1; j < N_CHAN; j++) begin
                    if (PAR_EFF[j] && (j != i))
                        chan_term[i] = chan_term[i] & (mon.axis_block_sigs[j] | mon.inst_idle_sigs[j]);
                end
            end
        end
    end
    assign raw_block = |chan_term;

    always_comb begin
        fidx_nxt = 5'd0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (mon.axis_block_sigs[i]) fidx_nxt = 5'(i);
        end
    end

    assign thr_eff = (mon.threshold == '0) ? CNT_W'(1) : mon.threshold;
    assign cnt_p1  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign bc_p1   = {1'b0, bc_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat = cnt_p1[CNT_W] ? cnt : cnt_p1[CNT_W-1:0];
    assign bc_sat  = bc_p1[CNT_W] ? bc_q : bc_p1[CNT_W-1:0];
    assign reach   = (cnt_p1 >= {1'b0, thr_eff});

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            info_q <= '0;
            fidx_q <= '0;
            bc_q   <= '0;
        end else if (mon.clear) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            info_q <= '0;
            fidx_q <= '0;
            bc_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_SUSPECT: begin
                    if (!raw_block) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        // From IDLE cnt is 0, so cnt+1 is the first counted cycle.
                        cnt <= (state == ST_IDLE) ? CNT_W'(1) : cnt_sat;
                        if ((state == ST_IDLE) ? (thr_eff == CNT_W'(1)) : reach) begin
                            state  <= ST_BLOCKED;
                            info_q <= mon.axis_block_sigs;
                            fidx_q <= fidx_nxt;
                            bc_q   <= CNT_W'(1);
                        end else begin
                            state <= ST_SUSPECT;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (!STICKY && !raw_block) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        info_q <= '0;
                        fidx_q <= '0;
                        bc_q   <= '0;
                    end else begin
                        bc_q <= bc_sat;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign mon.block           = (state == ST_BLOCKED);
    assign mon.axis_block_info = mon.block ? info_q : '0;
    assign mon.first_idx       = mon.block ? fidx_q : 5'd0;
    assign mon.block_cycles    = mon.block ? bc_q : '0;
endmodule
